// File: rtl/siso_shift_ctrl_if.sv
// Word-level handshake and serial chain signals between a producer/consumer,
// the SISO shift controller and the attached shift chain.
interface siso_shift_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             sr_i;
  logic             sr_o;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             busy;

  // Controller side.
  modport slave (
    input  in_valid, in_data, sr_o, out_ready,
    output in_ready, sr_i, out_valid, out_data, busy
  );

  // Producer/consumer and chain side.
  modport master (
    output in_valid, in_data, sr_o, out_ready,
    input  in_ready, sr_i, out_valid, out_data, busy
  );
endinterface

// File: rtl/siso_shift_ctrl.sv
// Sequencer for a free-running DEPTH-stage SISO shift chain: serialises one
// word MSB-first into the chain, captures the chain output DEPTH cycles later
// and presents the reassembled word on a valid/ready port.
module siso_shift_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  siso_shift_ctrl_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH + DEPTH + 1);

  // r_cnt holds (cycle - 1) while in SEND/DRAIN, cycle 0 being the accept cycle.
  localparam logic [CW-1:0] LastSend  = CW'(WIDTH - 1);
  localparam logic [CW-1:0] LastDrain = CW'(WIDTH + DEPTH - 1);
  localparam logic [CW-1:0] CapLo     = CW'(DEPTH);
  localparam logic [CW-1:0] CapHi     = CW'(DEPTH + WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StSend, StDrain, StDone} state_e;

  state_e           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_word;
  logic [WIDTH-1:0] r_cap;
  logic             r_sr_i;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;
  logic             w_cap_en;

  // Capture window: sr_o is only looked at here, so X outside it never enters r_cap.
  always_comb begin
    w_cap_en = ((r_state == StSend) || (r_state == StDrain)) &&
               (r_cnt >= CapLo) && (r_cnt <= CapHi);
  end

  // Controller FSM with registered outputs; r_word pre-shifted so its MSB is the next bit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_word      <= '0;
      r_cap       <= '0;
      r_sr_i      <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      if (w_cap_en) begin
        r_cap <= (r_cap << 1) | WIDTH'(bus.sr_o);
      end
      unique case (r_state)
        StIdle: begin
          if (bus.in_valid) begin
            r_word     <= bus.in_data << 1;
            r_sr_i     <= bus.in_data[WIDTH-1];
            r_cnt      <= '0;
            r_state    <= StSend;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        StSend: begin
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == LastSend) begin
            r_sr_i  <= 1'b0;
            r_state <= StDrain;
          end else begin
            r_sr_i <= r_word[WIDTH-1];
            r_word <= r_word << 1;
          end
        end
        StDrain: begin
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == LastDrain) begin
            r_state     <= StDone;
            r_out_valid <= 1'b1;
          end
        end
        StDone: begin
          if (bus.out_ready) begin
            r_state     <= StIdle;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.sr_i      = r_sr_i;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_cap;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_siso_shift_ctrl.sv
// Directed bench for siso_shift_ctrl: 8x4 instance plus a 1x1 instance, each
// with a behavioural shift chain model (the 8x4 one can flip a single bit).
module tb_siso_shift_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic inv = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic [3:0] chain;
  logic       chain1;

  siso_shift_ctrl_if #(.WIDTH(8)) bus ();
  siso_shift_ctrl_if #(.WIDTH(1)) bus1 ();

  siso_shift_ctrl #(.WIDTH(8), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  siso_shift_ctrl #(.WIDTH(1), .DEPTH(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Chain models sharing the controller reset; inv corrupts one entering bit.
  always @(posedge clk) begin
    if (!rst) begin
      chain  <= '0;
      chain1 <= 1'b0;
    end else begin
      chain  <= {chain[2:0], bus.sr_i ^ inv};
      chain1 <= bus1.sr_i;
    end
  end
  assign bus.sr_o  = chain[3];
  assign bus1.sr_o = chain1;

  // Offer d in the current (idle) cycle; returns at the negedge of cycle 1.
  task automatic accept(input logic [7:0] d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.sr_i !== 1'b0 || bus.out_valid !== 1'b0 ||
        bus.out_data !== 8'h00 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b sr_i=%b ov=%b od=%h busy=%b want 1 0 0 00 0",
               bus.in_ready, bus.sr_i, bus.out_valid, bus.out_data, bus.busy);
    end
    checks++;
    if (bus1.in_ready !== 1'b1 || bus1.out_valid !== 1'b0 || bus1.out_data !== 1'b0) begin
      errors++;
      $display("FAIL reset_min: got rdy=%b ov=%b od=%b want 1 0 0",
               bus1.in_ready, bus1.out_valid, bus1.out_data);
    end
  endtask

  task automatic test_basic;
    logic [7:0] w;
    w = 8'hA5;
    accept(w);
    for (int k = 1; k <= 12; k++) begin
      checks++;
      if (k <= 8) begin
        if (bus.sr_i !== w[8-k] || bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin
          errors++;
          $display("FAIL basic_send cycle %0d: got sr_i=%b rdy=%b busy=%b want %b 0 1",
                   k, bus.sr_i, bus.in_ready, bus.busy, w[8-k]);
        end
      end else begin
        if (bus.sr_i !== 1'b0 || bus.out_valid !== 1'b0 || bus.busy !== 1'b1) begin
          errors++;
          $display("FAIL basic_drain cycle %0d: got sr_i=%b ov=%b busy=%b want 0 0 1",
                   k, bus.sr_i, bus.out_valid, bus.busy);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hA5) begin
      errors++;
      $display("FAIL basic_out cycle 13: got ov=%b od=%h want 1 a5", bus.out_valid, bus.out_data);
    end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0 ||
        bus.out_data !== 8'hA5) begin
      errors++;
      $display("FAIL basic_idle cycle 14: got ov=%b rdy=%b busy=%b od=%h want 0 1 0 a5",
               bus.out_valid, bus.in_ready, bus.busy, bus.out_data);
    end
  endtask

  task automatic test_stall;
    bus.out_ready = 1'b0;
    accept(8'hA5);
    repeat (12) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hA5 || bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold %0d: got ov=%b od=%h rdy=%b want 1 a5 0",
                 i, bus.out_valid, bus.out_data, bus.in_ready);
      end
      // Offered word must be ignored while not ready.
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h11;
      @(negedge clk);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hA5) begin
      errors++;
      $display("FAIL stall_release: got ov=%b od=%h want 1 a5", bus.out_valid, bus.out_data);
    end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_data !== 8'hA5) begin
      errors++;
      $display("FAIL stall_idle: got ov=%b rdy=%b od=%h want 0 1 a5",
               bus.out_valid, bus.in_ready, bus.out_data);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] words [3];
    int         acc [3];
    int         n;
    words[0] = 8'hFF;
    words[1] = 8'h00;
    words[2] = 8'h81;
    bus.in_valid = 1'b1;
    bus.in_data  = words[0];
    for (int i = 0; i < 3; i++) begin
      n = 0;
      while (bus.in_ready !== 1'b1 && n < 40) begin
        @(negedge clk);
        n++;
      end
      acc[i] = cyc;
      @(negedge clk);
      if (i < 2) bus.in_data = words[i+1];
      else bus.in_valid = 1'b0;
      n = 0;
      while (bus.out_valid !== 1'b1 && n < 40) begin
        @(negedge clk);
        n++;
      end
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== words[i]) begin
        errors++;
        $display("FAIL b2b_word %0d: got ov=%b od=%h want 1 %h",
                 i, bus.out_valid, bus.out_data, words[i]);
      end
      if (i > 0) begin
        checks++;
        if (acc[i] - acc[i-1] != 14) begin
          errors++;
          $display("FAIL b2b_spacing %0d: got %0d cycles want 14", i, acc[i] - acc[i-1]);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    accept(8'hA5);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_data !== 8'h00 ||
        bus.busy !== 1'b0 || bus.sr_i !== 1'b0) begin
      errors++;
      $display("FAIL midreset_idle: got rdy=%b ov=%b od=%h busy=%b sr_i=%b want 1 0 00 0 0",
               bus.in_ready, bus.out_valid, bus.out_data, bus.busy, bus.sr_i);
    end
    accept(8'h3C);
    repeat (11) @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_early cycle 12: got ov=%b want 0", bus.out_valid);
    end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h3C) begin
      errors++;
      $display("FAIL midreset_word: got ov=%b od=%h want 1 3c", bus.out_valid, bus.out_data);
    end
    @(negedge clk);
  endtask

  task automatic test_chain_error;
    accept(8'hA5);
    @(negedge clk);
    inv = 1'b1;
    @(negedge clk);
    inv = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hE5) begin
      errors++;
      $display("FAIL chain_flip: got ov=%b od=%h want 1 e5", bus.out_valid, bus.out_data);
    end
    @(negedge clk);
  endtask

  task automatic test_min_size;
    bus1.in_valid = 1'b1;
    bus1.in_data  = 1'b1;
    @(negedge clk);
    bus1.in_valid = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      checks++;
      if (bus1.out_valid !== 1'b0 || bus1.busy !== 1'b1) begin
        errors++;
        $display("FAIL min_wait cycle %0d: got ov=%b busy=%b want 0 1",
                 k, bus1.out_valid, bus1.busy);
      end
      @(negedge clk);
    end
    checks++;
    if (bus1.out_valid !== 1'b1 || bus1.out_data !== 1'b1) begin
      errors++;
      $display("FAIL min_out cycle 3: got ov=%b od=%b want 1 1", bus1.out_valid, bus1.out_data);
    end
    @(negedge clk);
    checks++;
    if (bus1.in_ready !== 1'b1 || bus1.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL min_idle: got rdy=%b ov=%b want 1 0", bus1.in_ready, bus1.out_valid);
    end
  endtask

  initial begin
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.out_ready  = 1'b1;
    bus1.in_valid  = 1'b0;
    bus1.in_data   = '0;
    bus1.out_ready = 1'b1;
    @(negedge clk);
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_chain_error();
    test_min_size();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
